// File: rtl/gf163_pkg.sv
// Shared constants, state encoding and fold-count helpers for the GF(2^163) reducer.
// f(x) = x^163 + x^7 + x^6 + x^3 + 1 is fixed here and not configurable.
package gf163_pkg;

    localparam int M       = 163;
    localparam int PROD_W  = 325;
    localparam int UPPER_W = PROD_W - M;  // 162 bits that must be folded away
    localparam int NTAPS   = 4;
    localparam int TAPS [NTAPS] = '{0, 3, 6, 7};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic bit fold_bits_ok(input int fold_bits);
        return (fold_bits >= 1) && (fold_bits <= 156) && ((UPPER_W % fold_bits) == 0);
    endfunction

    // Falls back to 1 for illegal widths so elaboration reaches the explicit check
    function automatic int nfold(input int fold_bits);
        return fold_bits_ok(fold_bits) ? (UPPER_W / fold_bits) : 1;
    endfunction

endpackage

// File: rtl/gf163_fold_step.sv
// One fold of FOLD_BITS upper bits: the chunk selected by cnt_i is cleared and
// re-injected at offsets -163+tap, which always lands strictly below the chunk.
module gf163_fold_step
    import gf163_pkg::*;
#(
    parameter int FOLD_BITS = 54,
    parameter int CNT_W     = 2
) (
    input  logic [PROD_W-1:0] r_i,
    input  logic [CNT_W-1:0]  cnt_i,
    output logic [PROD_W-1:0] r_o
);

    localparam int NFOLD    = nfold(FOLD_BITS);
    localparam int LSB_BASE = M + (NFOLD - 1) * FOLD_BITS;
    localparam logic [PROD_W-1:0] LOW_ONES =
        {{(PROD_W - FOLD_BITS){1'b0}}, {FOLD_BITS{1'b1}}};

    logic [8:0]        sh;
    logic [PROD_W-1:0] mask;
    logic [PROD_W-1:0] chunk;

    always_comb begin
        sh    = 9'(LSB_BASE - int'(cnt_i) * FOLD_BITS);
        mask  = LOW_ONES << sh;
        chunk = r_i & mask;
        r_o   = r_i & ~mask;
        // x^j = x^(j-163) * (1 + x^3 + x^6 + x^7)
        for (int i = 0; i < NTAPS; i++) begin
            r_o = r_o ^ (chunk >> (M - TAPS[i]));
        end
    end

endmodule

// File: rtl/gf163_reduce.sv
// Multi-cycle reducer of a 325-bit carry-less product modulo x^163+x^7+x^6+x^3+1,
// one FOLD_BITS-wide chunk per cycle, with valid/ready on both sides.
module gf163_reduce
    import gf163_pkg::*;
#(
    parameter int FOLD_BITS = 54
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M-1:0]      out_c
);

    localparam int NFOLD = nfold(FOLD_BITS);
    localparam int CNT_W = (NFOLD > 1) ? $clog2(NFOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NFOLD - 1);

    if (!fold_bits_ok(FOLD_BITS)) begin : g_bad_fold_bits
        $fatal(1, "gf163_reduce: FOLD_BITS=%0d must divide 162 and be <= 156", FOLD_BITS);
    end

    state_e            state_q;
    logic [PROD_W-1:0] r_q;
    logic [PROD_W-1:0] r_d;
    logic [CNT_W-1:0]  cnt_q;

    gf163_fold_step #(
        .FOLD_BITS (FOLD_BITS),
        .CNT_W     (CNT_W)
    ) u_fold_step (
        .r_i   (r_q),
        .cnt_i (cnt_q),
        .r_o   (r_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        r_q     <= in_prod;
                        cnt_q   <= '0;
                        state_q <= FOLD;
                    end
                end
                FOLD: begin
                    r_q <= r_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_c     = r_q[M-1:0];

endmodule

// File: tb/tb_gf163_reduce.sv
// Directed and random checks of gf163_reduce for FOLD_BITS = 1, 54 and 81,
// against hand-computed residues and a bit-serial reduction model.
module tb_gf163_reduce;

    logic         clk;
    logic         rst;
    logic [2:0]   iv;
    logic [2:0]   ordy;
    logic [2:0]   irdy;
    logic [2:0]   ov;
    logic [324:0] ip [3];
    logic [162:0] oc [3];

    int NF [3] = '{162, 3, 2};
    int n_assert = 0;
    int n_fail   = 0;

    logic [324:0] p163;
    logic [324:0] p324;
    logic [162:0] e324;
    int           lat;

    gf163_reduce #(.FOLD_BITS(1)) u_fb1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_prod(ip[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_c(oc[0])
    );
    gf163_reduce #(.FOLD_BITS(54)) u_fb54 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_prod(ip[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_c(oc[1])
    );
    gf163_reduce #(.FOLD_BITS(81)) u_fb81 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_prod(ip[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_c(oc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [162:0] obs, input logic [162:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [162:0] ref_red(input logic [324:0] p);
        logic [324:0] v;
        logic [324:0] poly;
        v    = p;
        poly = (325'(1) << 163) | 325'h0C9;
        for (int i = 324; i >= 163; i--) begin
            if (v[i]) v = v ^ (poly << (i - 163));
        end
        return v[162:0];
    endfunction

    function automatic logic [324:0] rnd_prod();
        logic [324:0] v;
        v = '0;
        for (int i = 0; i < 11; i++) v = (v << 32) | 325'($urandom());
        return v;
    endfunction

    // Entered and left just after a falling edge; one full product round trip.
    task automatic run_one(input int k, input logic [324:0] p, input logic [162:0] exp,
                           input int stall, input string tag);
        int n;
        int l;
        ip[k]   = p;
        iv[k]   = 1'b1;
        ordy[k] = 1'b0;
        n = 0;
        while (!irdy[k] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, 163'(irdy[k]), 163'(1));
        @(negedge clk);
        iv[k] = 1'b0;
        l = 0;
        while (!ov[k] && l < 400) begin
            @(negedge clk);
            l++;
        end
        chk({tag, "_latency"}, 163'(l), 163'(NF[k]));
        for (int s = 0; s < stall; s++) begin
            chk({tag, "_hold"}, oc[k], exp);
            @(negedge clk);
        end
        chk({tag, "_out_c"}, oc[k], exp);
        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
        chk({tag, "_ov_drop"}, 163'(ov[k]), 163'(0));
    endtask

    initial begin
        p163 = 325'(1) << 163;
        p324 = 325'(1) << 324;
        e324 = '0;
        e324[161] = 1'b1;
        e324[12]  = 1'b1;
        e324[10]  = 1'b1;
        e324[5]   = 1'b1;
        e324[1]   = 1'b1;

        rst  = 1'b1;
        iv   = 3'b111;
        ordy = 3'b000;
        for (int k = 0; k < 3; k++) ip[k] = p163;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_in_ready", 163'(irdy[k]), 163'(1));
            chk("reset_out_valid", 163'(ov[k]), 163'(0));
            chk("reset_out_c", oc[k], 163'(0));
        end
        iv  = 3'b000;
        rst = 1'b0;
        @(negedge clk);

        run_one(1, p163, 163'h0C9, 0, "x163");
        run_one(1, p324, e324, 2, "x324");
        run_one(1, 325'h1234, 163'h1234, 0, "low_only");
        run_one(0, p324, e324, 1, "x324_fb1");
        run_one(2, p324, e324, 1, "x324_fb81");
        run_one(0, p163, 163'h0C9, 0, "x163_fb1");
        run_one(2, p163, 163'h0C9, 0, "x163_fb81");

        // Backpressure: second product offered continuously while the first is held
        ip[1]   = p163;
        iv[1]   = 1'b1;
        ordy[1] = 1'b0;
        chk("bp_idle_ready", 163'(irdy[1]), 163'(1));
        @(negedge clk);
        ip[1] = p324;
        lat = 0;
        while (!ov[1] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency1", 163'(lat), 163'(3));
        for (int s = 0; s < 5; s++) begin
            chk("bp_hold_out_c", oc[1], 163'h0C9);
            chk("bp_hold_valid", 163'(ov[1]), 163'(1));
            chk("bp_hold_in_ready", 163'(irdy[1]), 163'(0));
            @(negedge clk);
        end
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;
        chk("bp_after_hs_valid", 163'(ov[1]), 163'(0));
        chk("bp_after_hs_ready", 163'(irdy[1]), 163'(1));
        @(negedge clk);
        iv[1] = 1'b0;
        chk("bp_second_captured", 163'(irdy[1]), 163'(0));
        lat = 0;
        while (!ov[1] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency2", 163'(lat), 163'(3));
        chk("bp_second_out_c", oc[1], e324);
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;

        // Reset during the second FOLD cycle
        ip[1] = p324;
        iv[1] = 1'b1;
        chk("rst_idle_ready", 163'(irdy[1]), 163'(1));
        @(negedge clk);
        iv[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", 163'(ov[1]), 163'(0));
        chk("rst_mid_ready", 163'(irdy[1]), 163'(1));
        chk("rst_mid_out_c", oc[1], 163'(0));
        run_one(1, p163, 163'h0C9, 0, "post_rst");

        for (int i = 0; i < 100; i++) begin
            ip[0] = rnd_prod();
            run_one(0, ip[0], ref_red(ip[0]), $urandom_range(0, 3), "rnd_fb1");
        end
        for (int i = 0; i < 450; i++) begin
            ip[1] = rnd_prod();
            run_one(1, ip[1], ref_red(ip[1]), $urandom_range(0, 3), "rnd_fb54");
        end
        for (int i = 0; i < 450; i++) begin
            ip[2] = rnd_prod();
            run_one(2, ip[2], ref_red(ip[2]), $urandom_range(0, 3), "rnd_fb81");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
